// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch port: req/ready request channel plus rvalid response channel.
// One request outstanding; requests held until ready, responses never backpressured.
interface fetch_pc_unit_if #(
  parameter int WIDTH_PC   = 32,
  parameter int WIDTH_INST = 32
);
  logic                  imem_req;
  logic [WIDTH_PC-1:0]   imem_addr;
  logic                  imem_ready;
  logic                  imem_rvalid;
  logic [WIDTH_INST-1:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// IF stage: owns fetch PC, one-outstanding imem fetch, IF/ID register with flush and stall skid.
// 2 cycles per instruction (request + response); stall parks one response in a skid and blocks requests.
module fetch_pc_unit #(
  parameter int                  WIDTH_PC   = 32,
  parameter int                  WIDTH_INST = 32,
  parameter logic [WIDTH_PC-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSel,
  input  logic [WIDTH_PC-1:0]   branchPC,
  input  logic                  stall,
  fetch_pc_unit_if.master       imem,
  output logic [WIDTH_PC-1:0]   pc_ID,
  output logic [WIDTH_INST-1:0] inst_ID,
  output logic                  valid_ID,
  output logic                  misalign
);

  localparam logic [WIDTH_PC-1:0]   PC_LSB = WIDTH_PC'(1);
  localparam logic [WIDTH_PC-1:0]   PC_INC = WIDTH_PC'(4);
  localparam logic [WIDTH_INST-1:0] NOP    = WIDTH_INST'(32'h0000_0013);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_t;

  state_t                state, state_nxt;
  logic [WIDTH_PC-1:0]   pc_IF;
  logic                  skid_full;
  logic [WIDTH_PC-1:0]   skid_pc;
  logic [WIDTH_INST-1:0] skid_inst;

  logic                  take;
  logic [WIDTH_PC-1:0]   target;
  logic                  handshake;
  logic                  deliver;

  // ID operands may be stale under a stall, so a redirect is only honoured when not stalled.
  assign take      = PCSel & ~stall;
  assign target    = branchPC & ~PC_LSB;
  assign handshake = imem.imem_req & imem.imem_ready;
  assign deliver   = (state == S_WAIT) & imem.imem_rvalid & ~take;

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ:   if (handshake) state_nxt = take ? S_DROP : S_WAIT;
      S_WAIT: begin
        if (take)                  state_nxt = imem.imem_rvalid ? S_REQ : S_DROP;
        else if (imem.imem_rvalid) state_nxt = S_REQ;
      end
      S_DROP:  if (imem.imem_rvalid) state_nxt = S_REQ;
      default: state_nxt = S_REQ;
    endcase
  end

  always_comb begin
    imem.imem_req  = (state == S_REQ) & ~skid_full & ~rst;
    imem.imem_addr = pc_IF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_IF    <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= take & branchPC[1];
      if (take)         pc_IF <= target;
      else if (deliver) pc_IF <= pc_IF + PC_INC;
    end
  end

  // IF/ID register and its one-entry skid; a flush wins over everything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_ID  <= 1'b0;
      pc_ID     <= '0;
      inst_ID   <= NOP;
      skid_full <= 1'b0;
      skid_pc   <= '0;
      skid_inst <= NOP;
    end else if (take) begin
      valid_ID  <= 1'b0;
      skid_full <= 1'b0;
    end else if (stall) begin
      if (deliver) begin
        skid_full <= 1'b1;
        skid_pc   <= pc_IF;
        skid_inst <= imem.imem_rdata;
      end
    end else if (skid_full) begin
      valid_ID  <= 1'b1;
      pc_ID     <= skid_pc;
      inst_ID   <= skid_inst;
      skid_full <= 1'b0;
    end else if (deliver) begin
      valid_ID  <= 1'b1;
      pc_ID     <= pc_IF;
      inst_ID   <= imem.imem_rdata;
    end else begin
      valid_ID  <= 1'b0;
    end
  end

endmodule
